lpddr2_req_bridge: RTL and testbench

Responder for the CPU's LPDDR2 request port. It accepts the CPU's level-held `lpddr2_rreq`/`lpddr2_wreq`, address and write data, and runs exactly one single-beat Avalon-MM transaction per request assertion toward the LPDDR2 controller. Read data is returned with a one-cycle completion pulse. A watchdog bounds every transaction so a stalled controller cannot hang the core. It sits between the core's top level and the external memory controller, in the `mem_clk` domain.

---
 rtl/lpddr2_req_bridge.sv | 192 +++++++++++++++++++
 tb/tb_lpddr2_req_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lpddr2_req_bridge.sv
// Bridges the CPU's level-held LPDDR2 read/write requests onto single-beat Avalon-MM
// transactions, one per request assertion, with a watchdog bounding each transaction.
module lpddr2_req_bridge #(
    parameter int          ADDR_W   = 27,
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_cpu_address,
    input  logic [31:0]       i_cpu_write_data,
    input  logic              i_cpu_rreq,
    input  logic              i_cpu_wreq,
    output logic [31:0]       o_cpu_read_data,
    output logic              o_cpu_done,
    output logic              o_cpu_busy,
    output logic              o_timeout_err,
    output logic [ADDR_W+1:0] o_avm_address,
    output logic              o_avm_read,
    output logic              o_avm_write,
    output logic [31:0]       o_avm_writedata,
    output logic [3:0]        o_avm_byteenable,
    input  logic              i_avm_waitrequest,
    input  logic [31:0]       i_avm_readdata,
    input  logic              i_avm_readdatavalid
);

    // state     | meaning
    // S_IDLE    | no request pending, waiting for rreq/wreq
    // S_WR_CMD  | avm_write presented, waiting for waitrequest low
    // S_RD_CMD  | avm_read presented, waiting for waitrequest low
    // S_RD_WAIT | read accepted, waiting for readdatavalid
    // S_HOLD    | transaction finished, waiting for both requests to drop
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_RD_CMD,
        S_RD_WAIT,
        S_HOLD
    } state_t;

    localparam int               CNT_W  = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [31:0]       w_rdata_next;
    logic              r_done;
    logic              r_busy;
    logic              r_err;
    logic              r_rd;
    logic              r_wr;
    logic              w_done;
    logic              w_err_next;
    logic              w_latch_addr;
    logic              w_latch_data;
    logic              w_expire;
    logic              w_busy_next;

    assign w_expire = (r_cnt == CNT_TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_done       = 1'b0;
        w_err_next   = r_err;
        w_rdata_next = r_rdata;
        w_latch_addr = 1'b0;
        w_latch_data = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (i_cpu_wreq) begin
                    w_latch_addr = 1'b1;
                    w_latch_data = 1'b1;
                    w_next_state = S_WR_CMD;
                end else if (i_cpu_rreq) begin
                    w_latch_addr = 1'b1;
                    w_next_state = S_RD_CMD;
                end
            end
            S_WR_CMD: begin
                if (!i_avm_waitrequest) begin
                    w_done       = 1'b1;
                    w_next_state = S_HOLD;
                end else if (w_expire) begin
                    w_done       = 1'b1;
                    w_err_next   = 1'b1;
                    w_next_state = S_HOLD;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_RD_CMD: begin
                // data arriving with the accept completes the read outright
                if (!i_avm_waitrequest && i_avm_readdatavalid) begin
                    w_done       = 1'b1;
                    w_rdata_next = i_avm_readdata;
                    w_next_state = S_HOLD;
                end else if (w_expire) begin
                    w_done       = 1'b1;
                    w_err_next   = 1'b1;
                    w_rdata_next = ERR_DATA;
                    w_next_state = S_HOLD;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                    if (!i_avm_waitrequest) begin
                        w_next_state = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (i_avm_readdatavalid) begin
                    w_done       = 1'b1;
                    w_rdata_next = i_avm_readdata;
                    w_next_state = S_HOLD;
                end else if (w_expire) begin
                    w_done       = 1'b1;
                    w_err_next   = 1'b1;
                    w_rdata_next = ERR_DATA;
                    w_next_state = S_HOLD;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (!i_cpu_rreq && !i_cpu_wreq) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_busy_next = (w_next_state == S_WR_CMD) || (w_next_state == S_RD_CMD) ||
                         (w_next_state == S_RD_WAIT);

    // outputs are registered from the next state so they line up with r_state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_rdata <= w_rdata_next;
            r_done  <= w_done;
            r_busy  <= w_busy_next;
            r_err   <= w_err_next;
            r_rd    <= (w_next_state == S_RD_CMD);
            r_wr    <= (w_next_state == S_WR_CMD);
            if (w_latch_addr) begin
                r_addr <= i_cpu_address;
            end
            if (w_latch_data) begin
                r_wdata <= i_cpu_write_data;
            end
        end
    end

    assign o_cpu_read_data  = r_rdata;
    assign o_cpu_done       = r_done;
    assign o_cpu_busy       = r_busy;
    assign o_timeout_err    = r_err;
    assign o_avm_address    = {r_addr, 2'b00};
    assign o_avm_read       = r_rd;
    assign o_avm_write      = r_wr;
    assign o_avm_writedata  = r_wdata;
    assign o_avm_byteenable = 4'hF;

endmodule

// File: tb/tb_lpddr2_req_bridge.sv
// Scoreboard bench for lpddr2_req_bridge: stimulus queues expected commands and completions,
// a monitor process compares them whenever the bridge presents a command or a done pulse.
module tb_lpddr2_req_bridge;

    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [26:0] i_cpu_address;
    logic [31:0] i_cpu_write_data;
    logic        i_cpu_rreq;
    logic        i_cpu_wreq;
    logic [31:0] o_cpu_read_data;
    logic        o_cpu_done;
    logic        o_cpu_busy;
    logic        o_timeout_err;
    logic [28:0] o_avm_address;
    logic        o_avm_read;
    logic        o_avm_write;
    logic [31:0] o_avm_writedata;
    logic [3:0]  o_avm_byteenable;
    logic        i_avm_waitrequest;
    logic [31:0] i_avm_readdata;
    logic        i_avm_readdatavalid;

    lpddr2_req_bridge #(.ADDR_W(27), .TIMEOUT(T), .ERR_DATA(ERR)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_cpu_address       (i_cpu_address),
        .i_cpu_write_data    (i_cpu_write_data),
        .i_cpu_rreq          (i_cpu_rreq),
        .i_cpu_wreq          (i_cpu_wreq),
        .o_cpu_read_data     (o_cpu_read_data),
        .o_cpu_done          (o_cpu_done),
        .o_cpu_busy          (o_cpu_busy),
        .o_timeout_err       (o_timeout_err),
        .o_avm_address       (o_avm_address),
        .o_avm_read          (o_avm_read),
        .o_avm_write         (o_avm_write),
        .o_avm_writedata     (o_avm_writedata),
        .o_avm_byteenable    (o_avm_byteenable),
        .i_avm_waitrequest   (i_avm_waitrequest),
        .i_avm_readdata      (i_avm_readdata),
        .i_avm_readdatavalid (i_avm_readdatavalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [28:0] addr;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
    } done_t;

    cmd_t  cmd_q[$];
    done_t done_q[$];
    cmd_t  cur;
    done_t dexp;
    bit    have_cur = 0;
    bit    prev_cmd = 0;
    bit    cmd_now;

    int checks   = 0;
    int failures = 0;

    // reference state: last value the CPU should see and the sticky error flag
    logic [31:0] m_rdata;
    bit          m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_cmd = 0;
            have_cur = 0;
        end else begin
            cmd_now = o_avm_read | o_avm_write;
            if (cmd_now && !prev_cmd) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", 1, 0);
                    have_cur = 0;
                end else begin
                    cur      = cmd_q.pop_front();
                    have_cur = 1;
                end
            end
            if (cmd_now && have_cur) begin
                chk("cmd_is_write", o_avm_write, cur.wr);
                chk("cmd_is_read", o_avm_read, !cur.wr);
                chk("avm_address", o_avm_address, cur.addr);
                if (cur.wr) chk("avm_writedata", o_avm_writedata, cur.data);
            end
            prev_cmd = cmd_now;
            if (o_cpu_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    dexp = done_q.pop_front();
                    chk("done_read_data", o_cpu_read_data, dexp.rdata);
                    chk("done_timeout_err", o_timeout_err, dexp.err);
                end
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_done", o_cpu_done, 0);
        chk("rst_busy", o_cpu_busy, 0);
        chk("rst_err", o_timeout_err, 0);
        chk("rst_rdata", o_cpu_read_data, 0);
        chk("rst_avm_read", o_avm_read, 0);
        chk("rst_avm_write", o_avm_write, 0);
        chk("rst_avm_address", o_avm_address, 0);
        chk("rst_avm_writedata", o_avm_writedata, 0);
        chk("rst_byteenable", o_avm_byteenable, 4'hF);
    endtask

    // kind: 0 write, 1 read, 2 both requests together (write expected)
    // s: cycles waitrequest stays high; L: cycles from accept to readdatavalid
    task automatic do_txn(input int kind, input logic [26:0] addr, input logic [31:0] data,
                          input int s, input int L, input logic [31:0] rdata, input int hold);
        bit wr;
        bit to;
        int d;
        int last_c;
        int cmax;
        wr = (kind != 1);
        if (wr) begin
            to = (s > T - 1);
            d  = to ? T : s + 1;
        end else begin
            to = (s > T - 1) || (s + L > T - 1);
            d  = to ? T : s + L + 1;
        end
        last_c = (s < T - 1) ? s : T - 1;
        cmax   = d;
        if (!wr && (s + L + 1 > cmax)) cmax = s + L + 1;
        if (!wr) m_rdata = to ? ERR : rdata;
        if (to) m_err = 1;
        cmd_q.push_back('{wr, {addr, 2'b00}, data});
        done_q.push_back('{m_rdata, m_err});

        @(negedge clk);
        i_cpu_address     = addr;
        i_cpu_write_data  = data;
        i_cpu_wreq        = (kind != 1);
        i_cpu_rreq        = (kind != 0);
        i_avm_waitrequest = 1'b1;
        for (int c = 0; c <= cmax; c++) begin
            @(negedge clk);
            chk("cmd_active", o_avm_read | o_avm_write, c <= last_c);
            chk("cmd_exclusive", o_avm_read & o_avm_write, 0);
            chk("done_pulse", o_cpu_done, c == d);
            chk("busy", o_cpu_busy, c < d);
            if (c == 0) begin
                i_cpu_address    = 27'($urandom);
                i_cpu_write_data = $urandom;
            end
            i_avm_waitrequest   = (c < s);
            i_avm_readdatavalid = !wr && (c == s + L);
            i_avm_readdata      = i_avm_readdatavalid ? rdata : $urandom;
        end
        i_avm_readdatavalid = 1'b0;
        i_avm_waitrequest   = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_no_done", o_cpu_done, 0);
            chk("hold_no_cmd", o_avm_read | o_avm_write, 0);
        end
        @(negedge clk);
        i_cpu_wreq = 1'b0;
        i_cpu_rreq = 1'b0;
        @(negedge clk);
        chk("held_read_data", o_cpu_read_data, m_rdata);
        chk("sticky_err", o_timeout_err, m_err);
    endtask

    task automatic reset_mid_read();
        cmd_q.push_back('{1'b0, {27'h0ABCDEF, 2'b00}, 32'h0});
        @(negedge clk);
        i_cpu_address     = 27'h0ABCDEF;
        i_cpu_rreq        = 1'b1;
        i_avm_waitrequest = 1'b1;
        @(negedge clk);
        i_avm_waitrequest = 1'b0;
        @(negedge clk);
        i_avm_waitrequest = 1'b1;
        chk("rdwait_busy", o_cpu_busy, 1);
        chk("rdwait_cmd_dropped", o_avm_read, 0);
        @(negedge clk);
        #4;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        m_rdata = 32'h0;
        m_err   = 0;
        i_cpu_rreq = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
    endtask

    initial begin
        rst                 = 1'b1;
        i_cpu_address       = '0;
        i_cpu_write_data    = '0;
        i_cpu_rreq          = 1'b0;
        i_cpu_wreq          = 1'b0;
        i_avm_waitrequest   = 1'b1;
        i_avm_readdata      = '0;
        i_avm_readdatavalid = 1'b0;
        m_rdata             = 32'h0;
        m_err               = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        do_txn(0, 27'h10, 32'hCAFEF00D, 0, 0, 32'h0, 3);
        do_txn(1, 27'h2345, 32'h0, 3, 2, 32'h12345678, 1);
        do_txn(2, 27'h77, 32'hA5A5_0001, 1, 0, 32'h0, 2);
        do_txn(1, 27'h78, 32'h0, 0, 1, 32'h0BADF00D, 0);
        do_txn(1, 27'h100, 32'h0, 0, 0, 32'h11112222, 0);
        do_txn(0, 27'h101, 32'h33334444, T - 1, 0, 32'h0, 0);
        do_txn(1, 27'h102, 32'h0, 3, T - 4, 32'h55556666, 0);
        do_txn(1, 27'h103, 32'h0, T - 1, 0, 32'h77778888, 0);
        do_txn(1, 27'h200, 32'h0, T + 1, 1, 32'h99990000, 4);
        do_txn(1, 27'h201, 32'h0, 2, 9, 32'hFEEDFACE, 5);
        do_txn(0, 27'h202, 32'h13572468, T, 0, 32'h0, 0);
        reset_mid_read();
        do_txn(1, 27'h300, 32'h0, 1, 1, 32'h2468ACE0, 0);

        for (int i = 0; i < 40; i++) begin
            do_txn($urandom_range(0, 2), 27'($urandom), $urandom, $urandom_range(0, 9),
                   $urandom_range(0, 5), $urandom, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
